// File: rtl/uart_pkg.sv
// Frame constants and receiver state encoding shared by the UART transmitter and receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line in, received byte and status out; master is the receiver side.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 framing_error;
    logic                 busy;

    modport master (input rx, output data, data_valid, framing_error, busy);
    modport slave  (output rx, input data, data_valid, framing_error, busy);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level 1.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit validation, one-cycle valid / framing-error pulses.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_receiver_if.master  bus
);
    import uart_pkg::*;

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t            state, state_next;
    logic [CNT_W-1:0]     cyc_cnt, cyc_cnt_next;
    logic [2:0]           bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [DATA_BITS-1:0] data_q, data_next;
    logic                 valid_q, valid_next;
    logic                 ferr_q, ferr_next;
    logic                 busy_q;
    logic                 rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    always_comb begin
        state_next   = state;
        cyc_cnt_next = cyc_cnt + 1'b1;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        data_next    = data_q;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            IDLE: begin
                cyc_cnt_next = '0;
                bit_cnt_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                // A start bit that is gone by mid-bit is line noise, not a frame.
                if (cyc_cnt == HALF_LAST) begin
                    cyc_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cyc_cnt == BIT_LAST) begin
                    cyc_cnt_next        = '0;
                    shift_next[bit_cnt] = rx_s;
                    if (bit_cnt == LAST_BIT) state_next = STOP;
                    else                     bit_cnt_next = bit_cnt + 3'd1;
                end
            end
            STOP: begin
                if (cyc_cnt == BIT_LAST) begin
                    cyc_cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line recovers so a break is reported only once.
                cyc_cnt_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: begin
                cyc_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cyc_cnt <= cyc_cnt_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            data_q  <= data_next;
            valid_q <= valid_next;
            ferr_q  <= ferr_next;
            busy_q  <= (state_next != IDLE);
        end
    end

    assign bus.data          = data_q;
    assign bus.data_valid    = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy          = busy_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, 8N1, LSB first. It is the downstream stage of the team's UART transmitter and consumes the serial line that block drives. It samples an asynchronous `rx` line at mid-bit, validates the start and stop bits, and presents each received byte with a one-cycle valid pulse. Framing errors are flagged separately.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Legal values are ≥ 4. `HALF` = floor(`CLKS_PER_BIT`/2).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  asynchronous serial input. Idle level is 1.
- `data`  out  8  last correctly framed byte. Holds its value until the next good frame.
- `data_valid`  out  1  one-cycle pulse when `data` has been updated.
- `framing_error`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to form `rx_s`. All decisions use `rx_s` only.
- Reset values:
  - `data` = 8'h00
  - `data_valid` = 0
  - `framing_error` = 0
  - `busy` = 0
  - state = IDLE
  - bit counter = 0
  - cycle counter = 0
  - synchronizer flops = 1
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:** when `rx_s` == 0, go to START and clear the cycle counter.
- **START:** count to `HALF`-1.
  - At the sample point, if `rx_s` == 0, go to DATA and clear both counters.
  - If `rx_s` == 1, treat it as a glitch and return to IDLE with no output.
- **DATA:** sample `rx_s` every `CLKS_PER_BIT` cycles into shift register bit[bit counter], LSB first. After bit 7, go to STOP.
- **STOP:** sample `rx_s` after `CLKS_PER_BIT` cycles.
  - If 1: load `data` from the shift register, pulse `data_valid`, and go to IDLE.
  - If 0: pulse `framing_error`, leave `data` unchanged, and go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s` == 1, then go to IDLE. A line held low (break) never produces repeated frames.
- Cycle counter width is $clog2(`CLKS_PER_BIT`). Bit counter is 3 bits and never wraps within a frame.
- `data_valid` and `framing_error` are never high in the same cycle.
- Reset asserted mid-frame aborts the frame immediately. Nothing from the partial frame is output.

## Timing
- t0 is the clk edge at which IDLE first sees `rx_s` == 0. `rx_s` lags `rx` by 2 cycles.
- Sample points occur at t0 + `HALF` + k·`CLKS_PER_BIT`:
  - k=0: start bit
  - k=1..8: data bits 0..7
  - k=9: stop bit
- `data_valid` or `framing_error` is high for exactly one cycle, in cycle t0 + `HALF` + 9·`CLKS_PER_BIT` + 1.
- `data` changes in that same cycle.
- `busy` rises at t0+1 and falls the cycle after the STOP decision. For a good frame, that is the same cycle as `data_valid`.
- Back-to-back frames: the next start edge may be seen on the cycle immediately after the return to IDLE. No dead time is required beyond the half stop bit.
- All outputs are registered. There is no combinational path from `rx`.

## Structure
- `uart_pkg` holds:
  - `DATA_BITS` = 8
  - the state enum/localparams (IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4)
- The transmitter shares `uart_pkg` for frame constants.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer, with reset value 1.
- Counters, shift register, and FSM live in `uart_receiver`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- **Good frame:** drive 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) → `data` = 8'hA5 and one `data_valid` pulse exactly 2+8+144+1 cycles after the `rx` falling edge; `framing_error` stays 0.
- **Start glitch:** drive `rx` low for 4 cycles → no `data_valid`, `busy` returns to 0 within 12 cycles, `data` unchanged.
- **Framing error:** drive 0x3C with the stop bit held 0 for 40 cycles after a prior good 0x11 → one `framing_error` pulse, `data` stays 8'h11. A frame sent after `rx` returns high is received normally.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two `data_valid` pulses 160 cycles apart, `data` = 8'h00 then 8'hFF.
- **Reset mid-frame:** assert `reset` during data bit 3 → all outputs reset next cycle; the following frame 0x5A is received correctly.
